wb_timer_intc: RTL and testbench

//  Wishbone pipelined slave holding NTIMER 32-bit interval timers and a shared prescaler.

---
 rtl/wb_timer_intc.sv | 176 +++++++++++++++++
 tb/tb_wb_timer_intc.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer_intc.sv
// Wishbone pipelined slave: NTIMER 32-bit interval timers sharing one prescaler,
// with write-1-to-clear pending flags and registered per-timer interrupt lines.
module wb_timer_intc #(
   parameter int unsigned NTIMER = 3,
   parameter int unsigned AWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       adr_i,
   input  logic [31:0]       dat_i,
   output logic [31:0]       dat_o,
   input  logic              we_i,
   input  logic [3:0]        sel_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   output logic              ack_o,
   output logic              stall_o,
   output logic [NTIMER-1:0] irq_o
);

   localparam int unsigned WW = AWIDTH - 2;

   logic [WW-1:0]     w_word;
   logic              w_acc;
   logic              w_wr;
   logic              w_tick;
   logic              w_sel_status;
   logic              w_sel_enable;
   logic              w_sel_prescale;
   logic [NTIMER-1:0] w_sel_count;
   logic [NTIMER-1:0] w_sel_compare;
   logic [NTIMER-1:0] w_sel_ctrl;
   logic [NTIMER-1:0] w_match;
   logic [NTIMER-1:0] w_clr;
   logic [31:0]       w_rdata;
   logic              w_unused;

   logic [NTIMER-1:0] r_pending;
   logic [NTIMER-1:0] r_enable;
   logic [NTIMER-1:0] r_run;
   logic [NTIMER-1:0] r_reload;
   logic [NTIMER-1:0] r_irq;
   logic [15:0]       r_prescale;
   logic [15:0]       r_pcnt;
   logic [31:0]       r_count   [NTIMER];
   logic [31:0]       r_compare [NTIMER];
   logic              r_ack;
   logic [31:0]       r_dat;

   function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  lanes);
      logic [31:0] v;
      for (int unsigned b = 0; b < 4; b++)
         v[8*b +: 8] = lanes[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return v;
   endfunction

   assign w_word   = adr_i[AWIDTH-1:2];
   assign w_acc    = cyc_i & stb_i;
   assign w_wr     = w_acc & we_i;
   assign w_tick   = (r_pcnt == r_prescale);
   assign w_unused = ^{adr_i[31:AWIDTH], adr_i[1:0]};

   always_comb begin
      w_sel_status   = (w_word == WW'(0));
      w_sel_enable   = (w_word == WW'(1));
      w_sel_prescale = (w_word == WW'(2));
      w_sel_count    = '0;
      w_sel_compare  = '0;
      w_sel_ctrl     = '0;
      for (int unsigned i = 0; i < NTIMER; i++) begin
         w_sel_count[i]   = (w_word == WW'(4*i + 4));
         w_sel_compare[i] = (w_word == WW'(4*i + 5));
         w_sel_ctrl[i]    = (w_word == WW'(4*i + 6));
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_sel_status)   w_rdata[NTIMER-1:0] = r_pending;
      if (w_sel_enable)   w_rdata[NTIMER-1:0] = r_enable;
      if (w_sel_prescale) w_rdata[15:0]       = r_prescale;
      for (int unsigned i = 0; i < NTIMER; i++) begin
         if (w_sel_count[i])   w_rdata = r_count[i];
         if (w_sel_compare[i]) w_rdata = r_compare[i];
         if (w_sel_ctrl[i])    w_rdata[1:0] = {r_reload[i], r_run[i]};
      end
   end

   // A bus write to COUNT_i in a tick cycle suppresses that cycle's compare.
   always_comb begin
      w_match = '0;
      for (int unsigned i = 0; i < NTIMER; i++)
         w_match[i] = w_tick & r_run[i] & (r_count[i] == r_compare[i])
                      & ~(w_wr & w_sel_count[i]);
      w_clr = (w_wr & w_sel_status & sel_i[0]) ? dat_i[NTIMER-1:0] : '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_prescale <= '0;
         r_pcnt     <= '0;
      end else begin
         if (w_wr && w_sel_prescale) begin
            if (sel_i[0]) r_prescale[7:0]  <= dat_i[7:0];
            if (sel_i[1]) r_prescale[15:8] <= dat_i[15:8];
            r_pcnt <= '0;
         end else if (w_tick) begin
            r_pcnt <= '0;
         end else begin
            r_pcnt <= r_pcnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_run    <= '0;
         r_reload <= '0;
         for (int unsigned i = 0; i < NTIMER; i++) begin
            r_count[i]   <= '0;
            r_compare[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NTIMER; i++) begin
            if (w_wr && w_sel_count[i]) begin
               r_count[i] <= f_merge(r_count[i], dat_i, sel_i);
            end else if (w_tick && r_run[i]) begin
               if (r_count[i] == r_compare[i]) begin
                  if (r_reload[i]) r_count[i] <= '0;
               end else begin
                  r_count[i] <= r_count[i] + 32'd1;
               end
            end
            if (w_wr && w_sel_compare[i])
               r_compare[i] <= f_merge(r_compare[i], dat_i, sel_i);
            // Bus CTRL write has priority over the one-shot RUN clear.
            if (w_wr && w_sel_ctrl[i] && sel_i[0]) begin
               r_run[i]    <= dat_i[0];
               r_reload[i] <= dat_i[1];
            end else if (w_match[i] && !r_reload[i]) begin
               r_run[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_pending <= '0;
         r_enable  <= '0;
         r_irq     <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_match;
         if (w_wr && w_sel_enable && sel_i[0]) r_enable <= dat_i[NTIMER-1:0];
         r_irq <= r_pending & r_enable;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_acc;
         if (w_acc && !we_i) r_dat <= w_rdata;
      end
   end

   assign ack_o   = r_ack & cyc_i;
   assign dat_o   = r_dat;
   assign stall_o = 1'b0;
   assign irq_o   = r_irq;

endmodule

// File: tb/tb_wb_timer_intc.sv
// Self-checking bench for wb_timer_intc: register vector table, directed timer
// scenarios and a randomized bus phase against a behavioural model.
module tb_wb_timer_intc;

   localparam int unsigned NT = 3;

   logic          clk    = 1'b0;
   logic          rst_i  = 1'b1;
   logic [31:0]   adr_i  = '0;
   logic [31:0]   dat_i  = '0;
   logic          we_i   = 1'b0;
   logic [3:0]    sel_i  = '0;
   logic          cyc_i  = 1'b0;
   logic          stb_i  = 1'b0;
   logic [31:0]   dat_o;
   logic          ack_o;
   logic          stall_o;
   logic [NT-1:0] irq_o;

   int checks = 0;
   int errors = 0;

   logic          s_ack;
   logic [31:0]   s_dat;
   logic [NT-1:0] s_irq;

   always #5 clk = ~clk;

   wb_timer_intc #(.NTIMER(NT), .AWIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
      .we_i(we_i), .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
      .stall_o(stall_o), .irq_o(irq_o)
   );

   // Behavioural model; the prescaler is tracked as a phase from its last clear point.
   logic [NT-1:0] m_pend, m_en, m_irq, m_run, m_rel;
   logic [15:0]   m_ps;
   int unsigned   m_edge, m_base;
   logic [31:0]   m_cnt [NT];
   logic [31:0]   m_cmp [NT];
   logic          m_ackq, m_ack_rd;
   logic [31:0]   m_dat;

   function automatic void m_reset();
      m_pend = '0; m_en = '0; m_irq = '0; m_run = '0; m_rel = '0;
      m_ps = '0; m_edge = 0; m_base = 0;
      m_ackq = 1'b0; m_ack_rd = 1'b0; m_dat = '0;
      for (int t = 0; t < NT; t++) begin
         m_cnt[t] = '0;
         m_cmp[t] = '0;
      end
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int unsigned off, t, r;
      off = {24'd0, a[7:2], 2'b00};
      if (off == 0) return {29'd0, m_pend};
      if (off == 4) return {29'd0, m_en};
      if (off == 8) return {16'd0, m_ps};
      if (off >= 16 && off < 16 + 16*NT) begin
         t = (off - 16) / 16;
         r = (off - 16) % 16;
         if (r == 0) return m_cnt[t];
         if (r == 4) return m_cmp[t];
         if (r == 8) return {30'd0, m_rel[t], m_run[t]};
      end
      return 32'd0;
   endfunction

   function automatic void m_step(input logic c, input logic s, input logic w,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] sl);
      logic [31:0]   mask, rd;
      logic          tick, acc, wr;
      logic [NT-1:0] hit, clr, irq_n;
      int unsigned   off, per, base;
      mask  = {{8{sl[3]}}, {8{sl[2]}}, {8{sl[1]}}, {8{sl[0]}}};
      per   = 32'(m_ps) + 1;
      tick  = ((m_edge - m_base) % per) == 32'(m_ps);
      acc   = c & s;
      wr    = acc & w;
      off   = {24'd0, a[7:2], 2'b00};
      rd    = m_read(a);
      irq_n = m_pend & m_en;
      hit   = '0;
      for (int t = 0; t < NT; t++) begin
         base = 16 + 16*t;
         if (tick && m_run[t] && !(wr && off == base) && m_cnt[t] == m_cmp[t]) hit[t] = 1'b1;
         if (wr && off == base)        m_cnt[t] = (m_cnt[t] & ~mask) | (d & mask);
         else if (tick && m_run[t]) begin
            if (hit[t]) begin
               if (m_rel[t]) m_cnt[t] = 32'd0;
            end else m_cnt[t] = m_cnt[t] + 32'd1;
         end
         if (wr && off == base + 4)    m_cmp[t] = (m_cmp[t] & ~mask) | (d & mask);
         if (wr && off == base + 8 && sl[0]) begin
            m_run[t] = d[0];
            m_rel[t] = d[1];
         end else if (hit[t] && !m_rel[t]) m_run[t] = 1'b0;
      end
      clr    = (wr && off == 0 && sl[0]) ? d[NT-1:0] : '0;
      m_pend = (m_pend & ~clr) | hit;
      if (wr && off == 4 && sl[0]) m_en = d[NT-1:0];
      if (wr && off == 8) begin
         if (sl[0]) m_ps[7:0]  = d[7:0];
         if (sl[1]) m_ps[15:8] = d[15:8];
         m_base = m_edge + 1;
      end
      m_irq    = irq_n;
      m_ackq   = acc;
      m_ack_rd = acc & ~w;
      if (acc && !w) m_dat = rd;
      m_edge++;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc_step(input logic c, input logic s, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
      cyc_i = c; stb_i = s; we_i = w; adr_i = a; dat_i = d; sel_i = sl;
      @(negedge clk);
      s_ack = ack_o; s_dat = dat_o; s_irq = irq_o;
      chk("ack", 32'(ack_o), 32'(m_ackq & c));
      if (m_ackq && c && m_ack_rd) chk("rdata", dat_o, m_dat);
      chk("irq", 32'(irq_o), 32'(m_irq));
      chk("stall", 32'(stall_o), 32'd0);
      @(posedge clk);
      m_step(c, s, w, a, d, sl);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
      cyc_step(1'b1, 1'b1, 1'b1, a, d, sl);
      cyc_step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      cyc_step(1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0);
      cyc_step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      chk("rd_ack", 32'(s_ack), 32'd1);
      v = s_dat;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc_step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_i = 1'b1;
      #1;
      chk("rel_ack", 32'(ack_o), 32'd0);
      @(posedge clk);
      m_step(cyc_i, stb_i, we_i, adr_i, dat_i, sel_i);
      #1;
   endtask

   task automatic assert_reset();
      rst_i = 1'b0;
      #1;
      chk("rst_ack", 32'(ack_o), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      m_reset();
      repeat (2) @(posedge clk);
      release_reset();
   endtask

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   logic [31:0] atab [16] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                              32'h20, 32'h24, 32'h28, 32'h30, 32'h34, 32'h38, 32'h40, 32'hF8};

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tv[$];
      logic [31:0] v, a, d;
      logic [3:0]  sl;
      logic        c, s, w;
      int          acks, n;
      bit          found;

      m_reset();
      #1 rst_i = 1'b0;
      #2;
      chk("rst0_ack", 32'(ack_o), 32'd0);
      chk("rst0_dat", dat_o, 32'd0);
      chk("rst0_irq", 32'(irq_o), 32'd0);
      release_reset();

      rd(32'h00, v); chk("t1_status", v, 32'd0);
      rd(32'h04, v); chk("t1_enable", v, 32'd0);
      rd(32'h08, v); chk("t1_prescale", v, 32'd0);
      rd(32'h10, v); chk("t1_count0", v, 32'd0);
      chk("t1_irq", 32'(s_irq), 32'd0);

      tv.push_back('{1'b1, 32'h004, 32'h000000FF, 4'hF, 32'h0});
      tv.push_back('{1'b0, 32'h004, 32'h0,        4'h0, 32'h7});
      tv.push_back('{1'b0, 32'h104, 32'h0,        4'h0, 32'h7});
      tv.push_back('{1'b1, 32'h008, 32'h12345678, 4'hF, 32'h0});
      tv.push_back('{1'b0, 32'h008, 32'h0,        4'h0, 32'h5678});
      tv.push_back('{1'b1, 32'h008, 32'hFFFF0003, 4'h2, 32'h0});
      tv.push_back('{1'b0, 32'h008, 32'h0,        4'h0, 32'h0078});
      tv.push_back('{1'b1, 32'h00C, 32'hDEADBEEF, 4'hF, 32'h0});
      tv.push_back('{1'b0, 32'h00C, 32'h0,        4'h0, 32'h0});
      tv.push_back('{1'b1, 32'h014, 32'hCAFEF00D, 4'hF, 32'h0});
      tv.push_back('{1'b0, 32'h016, 32'h0,        4'h0, 32'hCAFEF00D});
      tv.push_back('{1'b1, 32'h010, 32'h01020304, 4'hC, 32'h0});
      tv.push_back('{1'b0, 32'h010, 32'h0,        4'h0, 32'h01020000});
      tv.push_back('{1'b1, 32'h018, 32'hFFFFFFFC, 4'hF, 32'h0});
      tv.push_back('{1'b0, 32'h018, 32'h0,        4'h0, 32'h0});
      tv.push_back('{1'b1, 32'h038, 32'h0000000E, 4'hF, 32'h0});
      tv.push_back('{1'b0, 32'h038, 32'h0,        4'h0, 32'h2});
      tv.push_back('{1'b0, 32'h01C, 32'h0,        4'h0, 32'h0});
      tv.push_back('{1'b0, 32'h040, 32'h0,        4'h0, 32'h0});
      tv.push_back('{1'b1, 32'h000, 32'h000000FF, 4'hF, 32'h0});
      tv.push_back('{1'b0, 32'h000, 32'h0,        4'h0, 32'h0});
      foreach (tv[k]) begin
         if (tv[k].we) wr(tv[k].adr, tv[k].dat, tv[k].sel);
         else begin
            rd(tv[k].adr, v);
            chk($sformatf("vec%0d", k), v, tv[k].exp);
         end
      end

      assert_reset();

      // Auto-reload timer 0, tick every cycle, matches every 6th edge.
      wr(32'h08, 32'd0, 4'hF);
      wr(32'h14, 32'd5, 4'hF);
      wr(32'h04, 32'd1, 4'hF);
      wr(32'h18, 32'd3, 4'hF);
      found = 1'b0; n = 0;
      for (int k = 1; k <= 40 && !found; k++) begin
         idle(1);
         if (s_irq[0]) begin found = 1'b1; n = k; end
      end
      chk("t2_irq_latency", 32'(n), 32'd7);
      idle(9);
      wr(32'h00, 32'd1, 4'hF);
      rd(32'h00, v); chk("t4_set_wins", v, 32'd1);
      wr(32'h00, 32'd1, 4'hF);
      chk("t4_irq_hold", 32'(s_irq[0]), 32'd1);
      idle(1);
      chk("t4_irq_drop", 32'(s_irq[0]), 32'd0);
      wr(32'h18, 32'd0, 4'hF);
      wr(32'h00, 32'd7, 4'hF);
      wr(32'h04, 32'd0, 4'hF);

      // One-shot timer 1 with prescale 3.
      wr(32'h08, 32'd3, 4'hF);
      wr(32'h24, 32'd2, 4'hF);
      wr(32'h28, 32'd1, 4'hF);
      idle(30);
      rd(32'h28, v); chk("t3_run_cleared", v, 32'd0);
      rd(32'h20, v); chk("t3_count_hold", v, 32'd2);
      rd(32'h00, v); chk("t3_pending", v, 32'd2);
      chk("t3_irq_masked", 32'(s_irq), 32'd0);

      // Timer 2 wraps through zero before matching; then a single-lane write.
      wr(32'h00, 32'd7, 4'hF);
      wr(32'h08, 32'd0, 4'hF);
      wr(32'h30, 32'hFFFFFFFF, 4'hF);
      wr(32'h34, 32'd1, 4'hF);
      wr(32'h38, 32'd1, 4'hF);
      idle(10);
      rd(32'h30, v); chk("t5_count", v, 32'd1);
      rd(32'h00, v); chk("t5_pending", v, 32'd4);
      rd(32'h38, v); chk("t5_run", v, 32'd0);
      wr(32'h34, 32'hAABBCCDD, 4'h1);
      rd(32'h34, v); chk("t5_byte_lane", v, 32'h000000DD);

      // Back-to-back reads with cyc dropped after the third accept.
      acks = 0;
      cyc_step(1'b1, 1'b1, 1'b0, 32'h04, 32'd0, 4'd0); if (s_ack) acks++;
      cyc_step(1'b1, 1'b1, 1'b0, 32'h08, 32'd0, 4'd0); if (s_ack) acks++;
      cyc_step(1'b1, 1'b1, 1'b0, 32'h00, 32'd0, 4'd0); if (s_ack) acks++;
      cyc_step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0); if (s_ack) acks++;
      cyc_step(1'b0, 1'b0, 1'b0, 32'h00, 32'd0, 4'd0); if (s_ack) acks++;
      chk("t6_acks", 32'(acks), 32'd2);

      // Asynchronous reset while timer 0 runs and a read ack is outstanding.
      wr(32'h10, 32'd0, 4'hF);
      wr(32'h04, 32'd7, 4'hF);
      wr(32'h18, 32'd3, 4'hF);
      idle(10);
      chk("t7_irq_pre", 32'(s_irq[0]), 32'd1);
      cyc_step(1'b1, 1'b1, 1'b0, 32'h14, 32'd0, 4'd0);
      #2;
      chk("t7_ack_pre", 32'(ack_o), 32'd1);
      assert_reset();
      idle(3);
      rd(32'h00, v); chk("t7_status", v, 32'd0);
      rd(32'h18, v); chk("t7_ctrl0", v, 32'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 800; k++) begin
         c  = ($urandom_range(0, 9) != 0);
         s  = ($urandom_range(0, 2) != 0);
         w  = 1'($urandom_range(0, 1));
         a  = atab[$urandom_range(0, 15)];
         case (a[7:0])
            8'h08:                                  d = $urandom_range(0, 3);
            8'h10, 8'h14, 8'h20, 8'h24, 8'h30, 8'h34: d = $urandom_range(0, 9);
            default:                                d = $urandom;
         endcase
         a  = a | ($urandom & 32'hFFFFFF00) | $urandom_range(0, 3);
         sl = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
         cyc_step(c, s, w, a, d, sl);
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
